pipelined_barrel_shifter: RTL and testbench

//  Parametrised, pipelined barrel shifter for the execute stage; successor to the single-cycle 32-bit shifter.
//  - Supports LSL, LSR, ASR and ROR.
//  - Supports immediate and register-specified shift amounts, with full ARM amount-range semantics
//    (register amounts up to 255).
//  - Valid/ready handshake on input and output; flush input for branch squash.
//  - Produces result, carry-out and a carry-no-write indicator for the flags unit.

---
 rtl/pipelined_barrel_shifter_if.sv | 30 +++
 rtl/pipelined_barrel_shifter.sv | 173 +++++++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_barrel_shifter_if.sv
// Operand/result handshake bundle for pipelined_barrel_shifter.
// The master drives operands and OutReady; the shifter (slave) returns the result side.
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 8
);
    logic             InValid;
    logic             InReady;
    logic [1:0]       Sh;
    logic [AMT_W-1:0] ShAmt;
    logic             ImmShift;
    logic [WIDTH-1:0] ShIn;
    logic             CFlag;
    logic             Flush;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] ShOut;
    logic             ShifterCarry;
    logic             ShifterCFlagNoWrite;

    modport master (
        output InValid, Sh, ShAmt, ImmShift, ShIn, CFlag, Flush, OutReady,
        input  InReady, OutValid, ShOut, ShifterCarry, ShifterCFlagNoWrite
    );

    modport slave (
        input  InValid, Sh, ShAmt, ImmShift, ShIn, CFlag, Flush, OutReady,
        output InReady, OutValid, ShOut, ShifterCarry, ShifterCFlagNoWrite
    );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined LSL/LSR/ASR/ROR barrel shifter with ARM amount semantics, 1 or 2 stages.
// Optional feature: define SHIFTER_RRX_EN to make immediate ROR #0 behave as RRX.
module pipelined_barrel_shifter #(
    parameter int WIDTH  = 32,
    parameter int AMT_W  = 8,
    parameter int STAGES = 1
) (
    input logic                     CLK,
    input logic                     RESETn,
    pipelined_barrel_shifter_if.slave bus
);
    localparam int LW = $clog2(WIDTH);
    localparam int AW = LW + 1;                        // clamped amount spans 0..WIDTH+1
    localparam int NW = (AMT_W > AW) ? AMT_W : AW;

`ifdef SHIFTER_RRX_EN
    localparam bit RRX_EN = 1'b1;
`else
    localparam bit RRX_EN = 1'b0;
`endif

    typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR} sh_e;

    // ext carries the operand plus one carry slot: {carry, data} for LSL/ROR, {data, carry} for LSR/ASR.
    typedef struct packed {
        sh_e            op;
        logic [WIDTH:0] ext;
        logic [AW-1:0]  amt;
        logic           no_write;
        logic           cflag;
    } op_t;

    function automatic logic [WIDTH:0] do_shift(input sh_e op, input logic [WIDTH:0] ext,
                                                input logic [AW-1:0] amt);
        logic [WIDTH-1:0] w_d;
        w_d = ext[WIDTH-1:0];
        case (op)
            SH_LSL:  do_shift = ext << amt;
            SH_LSR:  do_shift = ext >> amt;
            SH_ASR:  do_shift = $signed(ext) >>> amt;
            default: do_shift = {1'b0, (w_d >> amt) | (w_d << (AW'(WIDTH) - amt))};
        endcase
    endfunction

    sh_e            w_sh;
    logic [NW-1:0]  w_n;
    logic           w_rrx;
    op_t            w_dec;
    op_t            w_last;
    logic           w_last_valid;
    logic           w_adv;
    logic [WIDTH-1:0] w_res;
    logic           w_carry;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sh_out;
    logic             r_carry;
    logic             r_no_write;

    assign w_sh  = sh_e'(bus.Sh);
    assign w_adv = !r_out_valid || bus.OutReady;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_rrx = 1'b0;
        w_n   = NW'(bus.ShAmt);
        if (bus.ImmShift) begin
            w_n = NW'(bus.ShAmt[4:0]);
            if (bus.ShAmt[4:0] == 5'd0) begin
                if (w_sh == SH_LSR || w_sh == SH_ASR) w_n = NW'(WIDTH);
                else if (w_sh == SH_ROR)              w_rrx = RRX_EN;
            end
        end
    end

    // Out-of-range amounts are clamped so the plain shifter yields the saturated result and carry.
    always_comb begin
        w_dec.op       = w_sh;
        w_dec.cflag    = bus.CFlag;
        w_dec.no_write = (w_n == '0) && !w_rrx;
        w_dec.ext      = {1'b0, bus.ShIn};
        w_dec.amt      = (w_n > NW'(WIDTH + 1)) ? AW'(WIDTH + 1) : w_n[AW-1:0];
        case (w_sh)
            SH_LSL: ;
            SH_LSR: w_dec.ext = {bus.ShIn, 1'b0};
            SH_ASR: begin
                w_dec.ext = {bus.ShIn, 1'b0};
                if (w_n > NW'(WIDTH)) w_dec.amt = AW'(WIDTH);
            end
            default: w_dec.amt = AW'(w_n[LW-1:0]);
        endcase
        if (w_rrx) begin
            w_dec.op  = SH_LSR;
            w_dec.ext = {bus.CFlag, bus.ShIn};
            w_dec.amt = '0;
        end
    end

    generate
        if (STAGES == 2) begin : g_two
            op_t  w_s1_next;
            op_t  r_s1;
            logic r_s1_valid;

            always_comb begin
                w_s1_next     = w_dec;
                w_s1_next.ext = do_shift(w_dec.op, w_dec.ext, w_dec.amt & ~AW'(7));
                w_s1_next.amt = w_dec.amt & AW'(7);
            end

            // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
            always_ff @(posedge CLK) begin
                if (!RESETn)        r_s1_valid <= 1'b0;
                else if (bus.Flush) r_s1_valid <= 1'b0;
                else if (w_adv)     r_s1_valid <= bus.InValid;
            end

            // NOTE: the payload needs no reset; its valid bit qualifies it.
            always_ff @(posedge CLK) begin
                if (w_adv && bus.InValid) r_s1 <= w_s1_next;
            end

            always_comb begin
                w_last       = r_s1;
                w_last.ext   = do_shift(r_s1.op, r_s1.ext, r_s1.amt);
                w_last_valid = r_s1_valid;
            end
        end else begin : g_one
            always_comb begin
                w_last       = w_dec;
                w_last.ext   = do_shift(w_dec.op, w_dec.ext, w_dec.amt);
                w_last_valid = bus.InValid;
            end
        end
    endgenerate

    always_comb begin
        w_res   = w_last.ext[WIDTH:1];
        w_carry = w_last.ext[0];
        if (w_last.op == SH_LSL) begin
            w_res   = w_last.ext[WIDTH-1:0];
            w_carry = w_last.ext[WIDTH];
        end else if (w_last.op == SH_ROR) begin
            w_res   = w_last.ext[WIDTH-1:0];
            w_carry = w_last.ext[WIDTH-1];
        end
        if (w_last.no_write) w_carry = w_last.cflag;
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_out_valid <= 1'b0;
            r_sh_out    <= '0;
            r_carry     <= 1'b0;
            r_no_write  <= 1'b0;
        end else if (bus.Flush) begin
            r_out_valid <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= w_last_valid;
            if (w_last_valid) begin
                r_sh_out   <= w_res;
                r_carry    <= w_carry;
                r_no_write <= w_last.no_write;
            end
        end
    end

    assign bus.InReady             = w_adv;
    assign bus.OutValid            = r_out_valid;
    assign bus.ShOut               = r_sh_out;
    assign bus.ShifterCarry        = r_carry;
    assign bus.ShifterCFlagNoWrite = r_no_write;
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter: one STAGES=1 and one STAGES=2 instance.
module tb_pipelined_barrel_shifter;
    localparam int W  = 32;
    localparam int AW = 8;
    localparam int NV = 20;

    typedef struct packed {
        logic [1:0]    sh;
        logic [AW-1:0] amt;
        logic          imm;
        logic [W-1:0]  d;
        logic          c;
        logic [W-1:0]  eo;
        logic          ec;
        logic          enw;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs [NV];

    int           sent;
    int           got;
    logic         stalled;
    logic [W-1:0] held_out;
    logic         held_c;
    logic         held_nw;

    pipelined_barrel_shifter_if #(.WIDTH(W), .AMT_W(AW)) bus1 ();
    pipelined_barrel_shifter_if #(.WIDTH(W), .AMT_W(AW)) bus2 ();

    pipelined_barrel_shifter #(.WIDTH(W), .AMT_W(AW), .STAGES(1)) u_dut1 (
        .CLK(clk), .RESETn(rst_n), .bus(bus1)
    );
    pipelined_barrel_shifter #(.WIDTH(W), .AMT_W(AW), .STAGES(2)) u_dut2 (
        .CLK(clk), .RESETn(rst_n), .bus(bus2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input bit to1, input bit to2, input vec_t v);
        bus1.InValid = to1;      bus2.InValid = to2;
        bus1.Sh = v.sh;          bus2.Sh = v.sh;
        bus1.ShAmt = v.amt;      bus2.ShAmt = v.amt;
        bus1.ImmShift = v.imm;   bus2.ImmShift = v.imm;
        bus1.ShIn = v.d;         bus2.ShIn = v.d;
        bus1.CFlag = v.c;        bus2.CFlag = v.c;
    endtask

    task automatic idle_in();
        bus1.InValid = 1'b0;
        bus2.InValid = 1'b0;
    endtask

    task automatic check_dut1(input string tag, input vec_t v);
        check($sformatf("%s s1 valid", tag), W'(bus1.OutValid), W'(1'b1));
        check($sformatf("%s s1 out", tag), bus1.ShOut, v.eo);
        check($sformatf("%s s1 carry", tag), W'(bus1.ShifterCarry), W'(v.ec));
        check($sformatf("%s s1 nowrite", tag), W'(bus1.ShifterCFlagNoWrite), W'(v.enw));
    endtask

    task automatic check_dut2(input string tag, input vec_t v);
        check($sformatf("%s s2 valid", tag), W'(bus2.OutValid), W'(1'b1));
        check($sformatf("%s s2 out", tag), bus2.ShOut, v.eo);
        check($sformatf("%s s2 carry", tag), W'(bus2.ShifterCarry), W'(v.ec));
        check($sformatf("%s s2 nowrite", tag), W'(bus2.ShifterCFlagNoWrite), W'(v.enw));
    endtask

    initial begin
        //            sh    amt     imm   d              c     out            carry nowrite
        vecs[0]  = '{2'd0, 8'd32,  1'b0, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1]  = '{2'd0, 8'd33,  1'b0, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vecs[2]  = '{2'd2, 8'd0,   1'b1, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
`ifdef SHIFTER_RRX_EN
        vecs[3]  = '{2'd3, 8'd0,   1'b1, 32'h0000_0003, 1'b1, 32'h8000_0001, 1'b1, 1'b0};
`else
        vecs[3]  = '{2'd3, 8'd0,   1'b1, 32'h0000_0003, 1'b1, 32'h0000_0003, 1'b1, 1'b1};
`endif
        vecs[4]  = '{2'd3, 8'd64,  1'b0, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b0};
        vecs[5]  = '{2'd1, 8'd0,   1'b0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1};
        vecs[6]  = '{2'd0, 8'd4,   1'b1, 32'hF000_000F, 1'b0, 32'h0000_00F0, 1'b1, 1'b0};
        vecs[7]  = '{2'd1, 8'd8,   1'b0, 32'h1234_5680, 1'b1, 32'h0012_3456, 1'b1, 1'b0};
        vecs[8]  = '{2'd2, 8'd4,   1'b0, 32'h8000_0010, 1'b0, 32'hF800_0001, 1'b0, 1'b0};
        vecs[9]  = '{2'd3, 8'd8,   1'b0, 32'h1234_5678, 1'b0, 32'h7812_3456, 1'b0, 1'b0};
        vecs[10] = '{2'd3, 8'd4,   1'b1, 32'h0000_000F, 1'b0, 32'hF000_0000, 1'b1, 1'b0};
        vecs[11] = '{2'd1, 8'd0,   1'b1, 32'h8000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[12] = '{2'd2, 8'd200, 1'b0, 32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
        vecs[13] = '{2'd1, 8'd33,  1'b0, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
        vecs[14] = '{2'd0, 8'd0,   1'b0, 32'h0000_1234, 1'b1, 32'h0000_1234, 1'b1, 1'b1};
        vecs[15] = '{2'd3, 8'd33,  1'b0, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b1, 1'b0};
        vecs[16] = '{2'd1, 8'd31,  1'b0, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
        vecs[17] = '{2'd0, 8'd31,  1'b0, 32'h0000_0003, 1'b0, 32'h8000_0000, 1'b1, 1'b0};
        vecs[18] = '{2'd0, 8'hE1,  1'b1, 32'h8000_0001, 1'b0, 32'h0000_0002, 1'b1, 1'b0};
        vecs[19] = '{2'd2, 8'd0,   1'b0, 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1, 1'b1};

        rst_n = 1'b0;
        set_in(1'b0, 1'b0, vecs[0]);
        bus1.Flush = 1'b0;    bus2.Flush = 1'b0;
        bus1.OutReady = 1'b0; bus2.OutReady = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset s1 valid", W'(bus1.OutValid), '0);
        check("reset s1 out", bus1.ShOut, '0);
        check("reset s1 inready", W'(bus1.InReady), W'(1'b1));
        check("reset s1 carry", W'(bus1.ShifterCarry), '0);
        check("reset s1 nowrite", W'(bus1.ShifterCFlagNoWrite), '0);
        check("reset s2 valid", W'(bus2.OutValid), '0);
        check("reset s2 out", bus2.ShOut, '0);
        check("reset s2 inready", W'(bus2.InReady), W'(1'b1));

        // Single operations: consumer holds OutReady low so both latencies settle, then drains.
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            set_in(1'b1, 1'b1, vecs[i]);
            @(posedge clk); #1;
            idle_in();
            @(posedge clk);
            @(negedge clk);
            check_dut1($sformatf("vec%0d", i), vecs[i]);
            check_dut2($sformatf("vec%0d", i), vecs[i]);
            @(posedge clk); #1;
            bus1.OutReady = 1'b1; bus2.OutReady = 1'b1;
            @(posedge clk); #1;
            bus1.OutReady = 1'b0; bus2.OutReady = 1'b0;
        end

        // Back-to-back stream into the 2-stage pipe with a 3-cycle consumer stall.
        sent = 0;
        got = 0;
        stalled = 1'b0;
        held_out = '0;
        held_c = 1'b0;
        held_nw = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(posedge clk); #1;
            if (sent < 4) set_in(1'b0, 1'b1, vecs[6 + sent]);
            else          idle_in();
            bus2.OutReady = !(cyc >= 2 && cyc <= 4);
            @(negedge clk);
            if (stalled) begin
                check("stall valid held", W'(bus2.OutValid), W'(1'b1));
                check("stall out held", bus2.ShOut, held_out);
                check("stall carry held", W'(bus2.ShifterCarry), W'(held_c));
                check("stall nowrite held", W'(bus2.ShifterCFlagNoWrite), W'(held_nw));
            end
            stalled  = bus2.OutValid && !bus2.OutReady;
            held_out = bus2.ShOut;
            held_c   = bus2.ShifterCarry;
            held_nw  = bus2.ShifterCFlagNoWrite;
            if (bus2.InValid && bus2.InReady) sent++;
            if (bus2.OutValid && bus2.OutReady) begin
                check_dut2($sformatf("stream%0d", got), vecs[6 + got]);
                got++;
            end
        end
        check("stream results delivered", W'(got), W'(4));

        // Flush with live work in both pipes; the operand shown with Flush must never emerge.
        @(posedge clk); #1;
        bus1.OutReady = 1'b1; bus2.OutReady = 1'b1;
        set_in(1'b1, 1'b1, vecs[10]);
        @(posedge clk); #1;
        set_in(1'b1, 1'b1, vecs[11]);
        @(posedge clk); #1;
        set_in(1'b1, 1'b1, vecs[12]);
        bus1.Flush = 1'b1; bus2.Flush = 1'b1;
        @(negedge clk);
        check("preflush s1 valid", W'(bus1.OutValid), W'(1'b1));
        check("preflush s2 valid", W'(bus2.OutValid), W'(1'b1));
        @(posedge clk); #1;
        idle_in();
        bus1.Flush = 1'b0; bus2.Flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("flush s1 valid c%0d", k), W'(bus1.OutValid), '0);
            check($sformatf("flush s2 valid c%0d", k), W'(bus2.OutValid), '0);
        end

        // Reset while an operation is in flight drops it.
        @(posedge clk); #1;
        bus1.OutReady = 1'b0; bus2.OutReady = 1'b0;
        set_in(1'b1, 1'b1, vecs[9]);
        @(posedge clk); #1;
        idle_in();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("midreset s1 valid c%0d", k), W'(bus1.OutValid), '0);
            check($sformatf("midreset s2 valid c%0d", k), W'(bus2.OutValid), '0);
        end
        check("midreset s1 out", bus1.ShOut, '0);
        check("midreset s2 out", bus2.ShOut, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
